// File: rtl/seg7_scan_capture.sv
// ---------------------------------------------------------------------------
// seg7_scan_capture
//
// Receiving end of an active-low multiplexed 7-segment display bus. It
// watches the segment bus and the digit anodes. Each digit is accepted once
// its {anode, segment} pattern has been stable for STABLE_CYCLES consecutive
// samples. When every digit has been captured, the whole frame is published
// and frame_valid is pulsed for one cycle.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   seg_in      segment bus, active-low; [6:0] = a..g (bit6 = a), [7] = DP
//   an_in       digit anodes, active-low; legal when exactly one bit is 0
//   hex_out     recovered digits, digit i in [4i+3:4i]
//   dp_out      recovered decimal points, 1 = lit
//   blank_out   1 = digit was all-off
//   err_out     1 = digit pattern not a hex glyph and not blank
//   frame_valid one-cycle pulse when the outputs above take a new frame
//   frame_err   OR of err_out for the frame, valid with frame_valid
// ---------------------------------------------------------------------------
module seg7_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {SEEK, COUNT, HELD} state_t;

    state_t                  state_reg;
    logic [7:0]              count_reg;
    logic [NUM_DIGITS+7:0]   sample_reg;
    logic [NUM_DIGITS-1:0]   mask_reg;
    logic [4*NUM_DIGITS-1:0] store_hex_reg;
    logic [NUM_DIGITS-1:0]   store_dp_reg;
    logic [NUM_DIGITS-1:0]   store_blank_reg;
    logic [NUM_DIGITS-1:0]   store_err_reg;

    logic [NUM_DIGITS+7:0]   cur_sample;
    logic [NUM_DIGITS-1:0]   an_low;
    logic                    one_hot;
    logic                    match;
    logic                    capture;
    logic                    mask_full;
    logic [3:0]              dec_hex;
    logic                    dec_blank;
    logic                    dec_err;

    assign cur_sample = {an_in, seg_in};
    assign an_low     = ~an_in;
    // Exactly one anode driven low: non-zero and a power of two.
    assign one_hot    = (an_low != '0) &&
                        ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
    assign match      = (cur_sample == sample_reg);
    // The counter becomes STABLE_CYCLES on this edge, so this edge captures.
    assign capture    = (state_reg == COUNT) && one_hot && match &&
                        (count_reg == STABLE_M1);
    assign mask_full  = &mask_reg;

    // Glyph decode of the active-low a..g pattern.
    always_comb begin
        dec_hex   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_in[6:0])
            7'b0000001: dec_hex = 4'h0;
            7'b1001111: dec_hex = 4'h1;
            7'b0010010: dec_hex = 4'h2;
            7'b0000110: dec_hex = 4'h3;
            7'b1001100: dec_hex = 4'h4;
            7'b0100100: dec_hex = 4'h5;
            7'b0100000: dec_hex = 4'h6;
            7'b0001111: dec_hex = 4'h7;
            7'b0000000: dec_hex = 4'h8;
            7'b0000100: dec_hex = 4'h9;
            7'b0001000: dec_hex = 4'hA;
            7'b1100000: dec_hex = 4'hB;
            7'b0110001: dec_hex = 4'hC;
            7'b1000010: dec_hex = 4'hD;
            7'b0110000: dec_hex = 4'hE;
            7'b0111000: dec_hex = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_err = 1'b1;
        endcase
    end

    // Stability FSM and sample history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= SEEK;
            count_reg  <= 8'd0;
            sample_reg <= '0;
        end else begin
            sample_reg <= cur_sample;
            case (state_reg)
                SEEK: begin
                    if (one_hot) begin
                        count_reg <= 8'd1;
                        state_reg <= COUNT;
                    end else begin
                        count_reg <= 8'd0;
                    end
                end
                COUNT: begin
                    if (!one_hot) begin
                        count_reg <= 8'd0;
                        state_reg <= SEEK;
                    end else if (!match) begin
                        count_reg <= 8'd1;
                    end else begin
                        count_reg <= count_reg + 8'd1;
                        if (count_reg == STABLE_M1) begin
                            state_reg <= HELD;
                        end
                    end
                end
                HELD: begin
                    if (!one_hot) begin
                        count_reg <= 8'd0;
                        state_reg <= SEEK;
                    end else if (!match) begin
                        count_reg <= 8'd1;
                        state_reg <= COUNT;
                    end
                end
                default: begin
                    count_reg <= 8'd0;
                    state_reg <= SEEK;
                end
            endcase
        end
    end

    // Per-digit store, capture mask and frame publication. The mask clear on
    // the publish cycle only drops bits collected before it; a capture on
    // that same edge still lands in the new mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg        <= '0;
            store_hex_reg   <= '0;
            store_dp_reg    <= '0;
            store_blank_reg <= '0;
            store_err_reg   <= '0;
            hex_out         <= '0;
            dp_out          <= '0;
            blank_out       <= '0;
            err_out         <= '0;
            frame_valid     <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && an_low[i]) begin
                    store_hex_reg[4*i +: 4] <= dec_hex;
                    store_dp_reg[i]         <= ~seg_in[7];
                    store_blank_reg[i]      <= dec_blank;
                    store_err_reg[i]        <= dec_err;
                end
            end
            mask_reg <= (mask_full ? '0 : mask_reg) |
                        (capture ? an_low : '0);
            frame_valid <= mask_full;
            frame_err   <= mask_full && (|store_err_reg);
            if (mask_full) begin
                hex_out   <= store_hex_reg;
                dp_out    <= store_dp_reg;
                blank_out <= store_blank_reg;
                err_out   <= store_err_reg;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

    logic        clk;
    logic        rst_n;
    logic [7:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] hex_out;
    logic [3:0]  dp_out;
    logic [3:0]  blank_out;
    logic [3:0]  err_out;
    logic        frame_valid;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int fv_count = 0;
    int fv_base;
    logic last_ferr = 1'b0;

    // Segment bytes, DP off unless noted (bit7 = 1).
    localparam logic [7:0] S0 = 8'h81, S1 = 8'hCF, S2 = 8'h92, S7 = 8'h8F;
    localparam logic [7:0] S8 = 8'h80, SA = 8'h88, SF = 8'hB8;
    localparam logic [7:0] SBAD = 8'hFE, SBLK = 8'hFF, S1DP = 8'h4F;
    localparam logic [3:0] D0 = 4'b1110, D1 = 4'b1101, D2 = 4'b1011, D3 = 4'b0111;

    seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .an_in      (an_in),
        .hex_out    (hex_out),
        .dp_out     (dp_out),
        .blank_out  (blank_out),
        .err_out    (err_out),
        .frame_valid(frame_valid),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts frame_valid cycles and remembers the frame_err beside each one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            fv_count  = fv_count + 1;
            last_ferr = frame_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [3:0] an, input logic [7:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        an_in  = 4'hF;
        seg_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset hex_out", 32'(hex_out), 32'h0);
        check("reset dp_out", 32'(dp_out), 32'h0);
        check("reset blank_out", 32'(blank_out), 32'h0);
        check("reset err_out", 32'(err_out), 32'h0);
        check("reset frame_valid", 32'(frame_valid), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        show(4'hF, 8'hFF, 2);

        // Basic scan 1,2,A,F.
        fv_base = fv_count;
        show(D0, S1, 6); show(D1, S2, 6); show(D2, SA, 6); show(D3, SF, 6);
        check("scan1 pulses", 32'(fv_count - fv_base), 32'd1);
        check("scan1 hex_out", 32'(hex_out), 32'hFA21);
        check("scan1 dp_out", 32'(dp_out), 32'h0);
        check("scan1 err_out", 32'(err_out), 32'h0);
        check("scan1 blank_out", 32'(blank_out), 32'h0);
        check("scan1 frame_err", 32'(last_ferr), 32'h0);
        $display("scan1: hex_out=%h frames=%0d", hex_out, fv_count - fv_base);

        // Digit 2 shows 7 too briefly, then 8.
        fv_base = fv_count;
        show(D0, S1, 6); show(D1, S2, 6); show(D2, S7, 3); show(D2, S8, 6); show(D3, SF, 6);
        check("short7 pulses", 32'(fv_count - fv_base), 32'd1);
        check("short7 digit2", 32'(hex_out[11:8]), 32'h8);
        $display("short7: hex_out=%h", hex_out);

        // Illegal pattern on digit 1, blank digit 3.
        fv_base = fv_count;
        show(D0, S1, 6); show(D1, SBAD, 6); show(D2, SA, 6); show(D3, SBLK, 6);
        check("bad pulses", 32'(fv_count - fv_base), 32'd1);
        check("bad hex_out", 32'(hex_out), 32'h0A01);
        check("bad err_out", 32'(err_out), 32'b0010);
        check("bad blank_out", 32'(blank_out), 32'b1000);
        check("bad frame_err", 32'(last_ferr), 32'h1);
        $display("bad: hex_out=%h err_out=%b blank_out=%b", hex_out, err_out, blank_out);

        // Two anodes low: nothing captured, then a normal scan.
        fv_base = fv_count;
        show(4'b1100, S8, 10);
        check("twolow pulses", 32'(fv_count - fv_base), 32'd0);
        show(D0, S1, 6); show(D1, S2, 6); show(D2, SA, 6); show(D3, SF, 6);
        check("after twolow pulses", 32'(fv_count - fv_base), 32'd1);
        check("after twolow hex_out", 32'(hex_out), 32'hFA21);
        check("after twolow frame_err", 32'(last_ferr), 32'h0);
        check("after twolow err_out", 32'(err_out), 32'h0);
        $display("twolow: hex_out=%h frames=%0d", hex_out, fv_count - fv_base);

        // Reset after two captures discards them.
        fv_base = fv_count;
        show(D0, S1, 6); show(D1, S2, 6);
        rst_n = 1'b0;
        #1;
        check("midreset hex_out", 32'(hex_out), 32'h0);
        check("midreset dp_out", 32'(dp_out), 32'h0);
        check("midreset blank_out", 32'(blank_out), 32'h0);
        check("midreset err_out", 32'(err_out), 32'h0);
        check("midreset frame_valid", 32'(frame_valid), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        show(D2, S8, 6); show(D3, S0, 6);
        check("midreset partial pulses", 32'(fv_count - fv_base), 32'd0);
        show(D0, S1, 6); show(D1, S2, 6);
        check("midreset full pulses", 32'(fv_count - fv_base), 32'd1);
        check("midreset hex_out after", 32'(hex_out), 32'h0821);
        $display("midreset: hex_out=%h frames=%0d", hex_out, fv_count - fv_base);

        // DP on digit 0, two continuous scans.
        fv_base = fv_count;
        for (int k = 0; k < 2; k++) begin
            show(D0, S1DP, 6); show(D1, S2, 6); show(D2, SA, 6); show(D3, SF, 6);
        end
        check("dp pulses", 32'(fv_count - fv_base), 32'd2);
        check("dp dp_out", 32'(dp_out), 32'b0001);
        check("dp hex_out", 32'(hex_out), 32'hFA21);
        $display("dp: dp_out=%b frames=%0d", dp_out, fv_count - fv_base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
